// File: rtl/bp_reg_mem_burst_if.sv
// Byte-pipe bundle between a host and bp_reg_mem_burst: host-to-block and
// block-to-host valid/ready byte channels.
interface bp_reg_mem_burst_if;
    logic [7:0] i_bp_data;
    logic       i_bp_valid;
    logic       o_bp_ready;
    logic [7:0] o_bp_data;
    logic       o_bp_valid;
    logic       i_bp_ready;

    modport master (
        output i_bp_data, i_bp_valid, i_bp_ready,
        input  o_bp_ready, o_bp_data, o_bp_valid
    );

    modport slave (
        input  i_bp_data, i_bp_valid, i_bp_ready,
        output o_bp_ready, o_bp_data, o_bp_valid
    );
endinterface

// File: rtl/bp_reg_mem_burst.sv
// Byte-pipe register memory with command/length burst protocol.
// Optional macro BP_REG_MEM_BURST_WRAP_EN: address wraps from N_REG-1 (or 127) to 1.
module bp_reg_mem_burst #(
    parameter int         N_REG       = 63,
    parameter logic [7:0] VALUE0      = 8'h00,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    bp_reg_mem_burst_if.slave      bp,
    output logic [8*N_REG-1:0]     o_reg
);

    typedef enum logic [1:0] {ST_CMD, ST_LEN, ST_WDATA, ST_RDATA} state_t;

    localparam logic [6:0] LAST_ADDR = 7'(N_REG - 1);

    state_t     state;
    logic       wr_q;
    logic [6:0] addr;
    logic [6:0] addr_nxt;
    logic [7:0] cnt;
    logic       ready_q;
    logic       valid_q;
    logic [7:0] data_q;
    logic       in_acc;
    logic       out_acc;
    logic [7:0] mem  [1:N_REG-1];
    logic [7:0] view [128];

    assign bp.o_bp_ready = ready_q & i_cg;
    assign bp.o_bp_valid = valid_q;
    assign bp.o_bp_data  = data_q;

    assign in_acc  = bp.i_bp_valid & ready_q & i_cg;
    assign out_acc = valid_q & bp.i_bp_ready & i_cg;

    // Full 7-bit address view: register 0 is the constant ID, out-of-range reads as zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        view    = '{default: 8'h00};
        view[0] = VALUE0;
        for (int k = 1; k < N_REG; k++) view[k] = mem[k];
    end

    always_comb begin
`ifdef BP_REG_MEM_BURST_WRAP_EN
        if (addr == LAST_ADDR || addr == 7'd127) addr_nxt = 7'd1;
        else                                     addr_nxt = addr + 7'd1;
`else
        addr_nxt = (addr == 7'd127) ? 7'd127 : addr + 7'd1;
`endif
    end

    for (genvar g = 0; g < N_REG; g++) begin : g_oreg
        assign o_reg[8*g +: 8] = view[g];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_CMD;
            wr_q    <= 1'b0;
            addr    <= 7'd0;
            cnt     <= 8'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            // NOTE: the register file is reset explicitly because its reset value is architectural.
            for (int k = 1; k < N_REG; k++) mem[k] <= RESET_VALUE;
        end else if (i_cg) begin
            unique case (state)
                ST_CMD: if (in_acc) begin
                    wr_q  <= bp.i_bp_data[7];
                    addr  <= bp.i_bp_data[6:0];
                    state <= ST_LEN;
                end
                ST_LEN: if (in_acc) begin
                    cnt <= bp.i_bp_data;
                    if (wr_q) begin
                        state <= ST_WDATA;
                    end else begin
                        state   <= ST_RDATA;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        data_q  <= view[addr];
                        addr    <= addr_nxt;
                    end
                end
                ST_WDATA: if (in_acc) begin
                    // Address 0 and out-of-range addresses match no entry, so the write drops.
                    for (int k = 1; k < N_REG; k++)
                        if (addr == 7'(k)) mem[k] <= bp.i_bp_data;
                    addr <= addr_nxt;
                    if (cnt == 8'd0) state <= ST_CMD;
                    else             cnt   <= cnt - 8'd1;
                end
                ST_RDATA: if (out_acc) begin
                    if (cnt == 8'd0) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_CMD;
                    end else begin
                        cnt    <= cnt - 8'd1;
                        data_q <= view[addr];
                        addr   <= addr_nxt;
                    end
                end
                default: state <= ST_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_reg_mem_burst.sv
// Directed self-checking bench for bp_reg_mem_burst (N_REG=5, VALUE0=0x57).
// Works with or without BP_REG_MEM_BURST_WRAP_EN defined.
module tb_bp_reg_mem_burst;
    localparam int         N_REG = 5;
    localparam logic [7:0] V0    = 8'h57;
    localparam logic [7:0] RV    = 8'hC3;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_cg;
    logic [8*N_REG-1:0] o_reg;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rd_buf [16];
    int         rd_n;
    int         rd_gaps;

    bp_reg_mem_burst_if bp ();

    bp_reg_mem_burst #(.N_REG(N_REG), .VALUE0(V0), .RESET_VALUE(RV)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_cg  (i_cg),
        .bp    (bp.slave),
        .o_reg (o_reg)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one host byte and returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bp.i_bp_data  = b;
        bp.i_bp_valid = 1'b1;
        while (!bp.o_bp_ready && t < 50) begin
            @(posedge i_clk); #1; t++;
        end
        if (!bp.o_bp_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: o_bp_ready=%b required 1 (byte %h)", bp.o_bp_ready, b);
        end
        @(posedge i_clk); #1;
        bp.i_bp_valid = 1'b0;
    endtask

    // Issues a read command and collects len+1 bytes with i_bp_ready held high.
    task automatic read_burst(input logic [7:0] cmd, input logic [7:0] len);
        int t = 0;
        rd_n = 0; rd_gaps = 0;
        bp.i_bp_ready = 1'b1;
        send_byte(cmd);
        send_byte(len);
        while (rd_n < int'(len) + 1 && t < 600) begin
            if (bp.o_bp_valid) begin
                if (rd_n < 16) rd_buf[rd_n] = bp.o_bp_data;
                rd_n++;
            end else begin
                rd_gaps++;
            end
            @(posedge i_clk); #1; t++;
        end
    endtask

    task automatic test_reset;
        logic [8*N_REG-1:0] exp;
        exp = {RV, RV, RV, RV, V0};
        i_rst = 1'b1; i_cg = 1'b1;
        bp.i_bp_valid = 1'b0; bp.i_bp_data = 8'h00; bp.i_bp_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        n_checks++; if (o_reg !== exp) begin n_fail++; $display("FAIL reset_oreg: got %h want %h", o_reg, exp); end
        n_checks++; if (bp.o_bp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bp.o_bp_valid); end
        n_checks++; if (bp.o_bp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bp.o_bp_data); end
        n_checks++; if (bp.o_bp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bp.o_bp_ready); end
    endtask

    task automatic test_write;
        logic [8*N_REG-1:0] exp;
        exp = {RV, 8'hBB, 8'hAA, RV, V0};
        send_byte(8'h82); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        n_checks++; if (o_reg !== exp) begin n_fail++; $display("FAIL write_oreg: got %h want %h", o_reg, exp); end
    endtask

    task automatic test_read;
        read_burst(8'h02, 8'h01);
        n_checks++; if (rd_n !== 2) begin n_fail++; $display("FAIL read_count: got %0d want 2", rd_n); end
        n_checks++; if (rd_gaps !== 0) begin n_fail++; $display("FAIL read_latency: got %0d idle cycles want 0", rd_gaps); end
        n_checks++; if (rd_buf[0] !== 8'hAA) begin n_fail++; $display("FAIL read_b0: got %h want aa", rd_buf[0]); end
        n_checks++; if (rd_buf[1] !== 8'hBB) begin n_fail++; $display("FAIL read_b1: got %h want bb", rd_buf[1]); end
        n_checks++; if (bp.o_bp_valid !== 1'b0 || bp.o_bp_ready !== 1'b1) begin
            n_fail++; $display("FAIL read_end: valid=%b ready=%b want 0/1", bp.o_bp_valid, bp.o_bp_ready);
        end
    endtask

    task automatic test_value0;
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h12);
        n_checks++; if (o_reg[7:0] !== V0) begin n_fail++; $display("FAIL v0_oreg: got %h want %h", o_reg[7:0], V0); end
        n_checks++; if (o_reg[15:8] !== RV) begin n_fail++; $display("FAIL v0_reg1: got %h want %h", o_reg[15:8], RV); end
        read_burst(8'h00, 8'h00);
        n_checks++; if (rd_n !== 1 || rd_buf[0] !== V0) begin
            n_fail++; $display("FAIL v0_read: got n=%0d byte=%h want n=1 byte=%h", rd_n, rd_buf[0], V0);
        end
    endtask

    task automatic test_addr_edge;
        logic [8*N_REG-1:0] exp;
        logic [7:0]         e1, e2;
`ifdef BP_REG_MEM_BURST_WRAP_EN
        exp = {8'h11, 8'hBB, 8'h33, 8'h22, V0};
        e1 = 8'h22; e2 = 8'h33;
`else
        exp = {8'h11, 8'hBB, 8'hAA, RV, V0};
        e1 = 8'h00; e2 = 8'h00;
`endif
        send_byte(8'h84); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n_checks++; if (o_reg !== exp) begin n_fail++; $display("FAIL edge_oreg: got %h want %h", o_reg, exp); end
        read_burst(8'h04, 8'h02);
        n_checks++; if (rd_n !== 3 || rd_gaps !== 0) begin n_fail++; $display("FAIL edge_count: got n=%0d gaps=%0d want 3/0", rd_n, rd_gaps); end
        n_checks++; if (rd_buf[0] !== 8'h11) begin n_fail++; $display("FAIL edge_b0: got %h want 11", rd_buf[0]); end
        n_checks++; if (rd_buf[1] !== e1) begin n_fail++; $display("FAIL edge_b1: got %h want %h", rd_buf[1], e1); end
        n_checks++; if (rd_buf[2] !== e2) begin n_fail++; $display("FAIL edge_b2: got %h want %h", rd_buf[2], e2); end
    endtask

    // mode 0 stalls with i_bp_ready low for 3 cycles, mode 1 with i_cg low for 2.
    task automatic test_stall;
        logic [7:0] exp [4];
        logic [7:0] got [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_byte(8'h81); send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_byte(exp[i]);
        for (int mode = 0; mode < 2; mode++) begin
            bp.i_bp_ready = 1'b1;
            send_byte(8'h01); send_byte(8'h03);
            for (int i = 0; i < 4; i++) begin
                if (i == 2) begin
                    if (mode == 0) bp.i_bp_ready = 1'b0;
                    else           i_cg = 1'b0;
                    for (int s = 0; s < (mode == 0 ? 3 : 2); s++) begin
                        @(posedge i_clk); #1;
                        n_checks++; if (bp.o_bp_valid !== 1'b1 || bp.o_bp_data !== 8'hC3) begin
                            n_fail++; $display("FAIL stall_hold m%0d: valid=%b data=%h want 1/c3", mode, bp.o_bp_valid, bp.o_bp_data);
                        end
                    end
                    bp.i_bp_ready = 1'b1; i_cg = 1'b1;
                end
                got[i] = bp.o_bp_valid ? bp.o_bp_data : 8'hxx;
                @(posedge i_clk); #1;
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (got[i] !== exp[i]) begin
                    n_fail++; $display("FAIL stall_byte m%0d[%0d]: got %h want %h", mode, i, got[i], exp[i]);
                end
            end
            n_checks++; if (bp.o_bp_valid !== 1'b0 || bp.o_bp_ready !== 1'b1) begin
                n_fail++; $display("FAIL stall_end m%0d: valid=%b ready=%b want 0/1", mode, bp.o_bp_valid, bp.o_bp_ready);
            end
        end
        i_cg = 1'b0; #1;
        n_checks++; if (bp.o_bp_ready !== 1'b0) begin n_fail++; $display("FAIL cg_ready: got %b want 0", bp.o_bp_ready); end
        i_cg = 1'b1; #1;
    endtask

    task automatic test_reset_mid;
        logic [8*N_REG-1:0] exp;
        exp = {RV, RV, RV, RV, V0};
        send_byte(8'h81); send_byte(8'h02); send_byte(8'h5A);
        n_checks++; if (o_reg[15:8] !== 8'h5A) begin n_fail++; $display("FAIL mid_pre: got %h want 5a", o_reg[15:8]); end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        n_checks++; if (o_reg !== exp) begin n_fail++; $display("FAIL mid_oreg: got %h want %h", o_reg, exp); end
        n_checks++; if (bp.o_bp_valid !== 1'b0 || bp.o_bp_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_hs: valid=%b ready=%b want 0/1", bp.o_bp_valid, bp.o_bp_ready);
        end
        read_burst(8'h03, 8'h00);
        n_checks++; if (rd_n !== 1 || rd_gaps !== 0 || rd_buf[0] !== RV) begin
            n_fail++; $display("FAIL mid_read: got n=%0d gaps=%0d byte=%h want 1/0/%h", rd_n, rd_gaps, rd_buf[0], RV);
        end
        n_checks++; if (bp.o_bp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_end: valid=%b want 0", bp.o_bp_valid); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_value0;
        test_addr_edge;
        test_stall;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
